cache_err_seq: RTL and testbench

- Cache-error exception sequencer in CP0. Sits directly upstream of the ErrorEPC register unit.
- Captures I-cache and D-cache parity/ECC error reports together with the faulting PC and delay-slot flag.
- Requests a pipeline flush, then issues the one-cycle cache_err commit pulse (with stable pc_p/bd_p) to the ErrorEPC unit and sets Status.ERL.
- Finally hands the cache-error vector to the fetch redirect logic.

---
 rtl/cache_err_seq_pkg.sv | 30 +++
 rtl/cache_err_seq_tmo_cnt.sv | 28 ++
 rtl/cache_err_seq.sv | 161 ++++++++++++++++
 tb/tb_cache_err_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_err_seq_pkg.sv
// Shared CP0 definitions for the cache-error sequencer: state encodings,
// default exception vectors and err_src bit positions.
package cache_err_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [31:0] VEC_BEV1_DEF  = 32'hBFC00300;
  localparam logic [31:0] VEC_BEV0_DEF  = 32'hA0000100;
  localparam int          FLUSH_TMO_DEF = 16;

  // Width of the flush timeout counter; FLUSH_TMO is limited to 2..255.
  localparam int TMO_W = 8;

  localparam int SRC_IC = 0;
  localparam int SRC_DC = 1;

  function automatic logic [1:0] src_bits(input logic ic, input logic dc);
    logic [1:0] s;
    s         = 2'b00;
    s[SRC_IC] = ic;
    s[SRC_DC] = dc;
    return s;
  endfunction

endpackage

// File: rtl/cache_err_seq_tmo_cnt.sv
// Flush timeout down-counter: load on accept, decrement while enabled,
// expired is high once the count has run down to zero.
module cache_err_tmo_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/cache_err_seq.sv
// CP0 cache-error exception sequencer: capture -> flush -> commit -> redirect.
// Optional saturating error counter enabled by defining CACHE_ERR_CNT_EN.
module cache_err_seq
  import cache_err_seq_pkg::*;
#(
  parameter logic [31:0] VEC_BEV1  = VEC_BEV1_DEF,
  parameter logic [31:0] VEC_BEV0  = VEC_BEV0_DEF,
  parameter int          FLUSH_TMO = FLUSH_TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_err,
  input  logic        dc_err,
  input  logic [31:0] err_pc,
  input  logic        err_bd,
  input  logic        erl,
  input  logic        bev,
  input  logic        flush_ack,
  input  logic        redirect_ack,
`ifdef CACHE_ERR_CNT_EN
  input  logic        cnt_clr,
  output logic [7:0]  err_cnt,
`endif
  output logic        flush_req,
  output logic        cache_err,
  output logic [31:0] pc_p,
  output logic        bd_p,
  output logic        erl_set,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  err_src,
  output logic        flush_tmo,
  output logic        busy
);

  state_t      state_reg, state_next;
  logic        accept;
  logic        tmo_expired;
  logic        tmo_hit;
  logic [1:0]  src_next;
  logic [31:0] pc_p_reg;
  logic        bd_p_reg;
  logic [1:0]  err_src_reg;
  logic        flush_tmo_reg;
  logic [31:0] redirect_pc_reg;

  // Nested errors (ERL already set) and anything arriving while busy are dropped.
  assign accept   = (state_reg == ST_IDLE) && (ic_err || dc_err) && !erl;
  assign tmo_hit  = (state_reg == ST_FLUSH) && tmo_expired && !flush_ack;
  assign src_next = src_bits(ic_err, dc_err);

  cache_err_tmo_cnt #(
    .W (TMO_W)
  ) u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (state_reg == ST_FLUSH),
    .load_val (TMO_W'(FLUSH_TMO - 1)),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_req      = 1'b0;
    cache_err      = 1'b0;
    erl_set        = 1'b0;
    redirect_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack || tmo_expired) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        cache_err  = 1'b1;
        erl_set    = 1'b1;
        state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Faulting PC/BD only move on an IDLE accept, keeping them coherent with cache_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p_reg <= '0;
      bd_p_reg <= 1'b0;
    end else if (accept) begin
      pc_p_reg <= err_pc;
      bd_p_reg <= err_bd;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        err_src_reg[gi] <= 1'b0;
      end else if (accept) begin
        err_src_reg[gi] <= src_next[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_tmo_reg <= 1'b0;
    end else if (accept) begin
      flush_tmo_reg <= 1'b0;
    end else if (tmo_hit) begin
      flush_tmo_reg <= 1'b1;
    end
  end

  // BEV is sampled on the commit cycle, not at error capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pc_reg <= '0;
    end else if (state_reg == ST_COMMIT) begin
      redirect_pc_reg <= bev ? VEC_BEV1 : VEC_BEV0;
    end
  end

`ifdef CACHE_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg <= 8'h00;
    end else if (cnt_clr) begin
      err_cnt_reg <= 8'h00;
    end else if (accept && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'h01;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

  assign pc_p        = pc_p_reg;
  assign bd_p        = bd_p_reg;
  assign err_src     = err_src_reg;
  assign flush_tmo   = flush_tmo_reg;
  assign redirect_pc = redirect_pc_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cache_err_seq.sv
// Directed + randomized self-checking bench for cache_err_seq.
// Expected values come from a sequence-level model of the error flow.
module tb_cache_err_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_err, dc_err, err_bd, erl, bev, flush_ack, redirect_ack;
  logic [31:0] err_pc;
  logic        flush_req, cache_err, bd_p, erl_set, redirect_valid, flush_tmo, busy;
  logic [31:0] pc_p, redirect_pc;
  logic [1:0]  err_src;
`ifdef CACHE_ERR_CNT_EN
  logic        cnt_clr;
  logic [7:0]  err_cnt;
`endif

  int          n_cmp = 0;
  int          n_mis = 0;
  int          seq_id = 0;
  int          exp_cnt = 0;
  logic [31:0] last_pc;
  logic        last_bd;

  always #5 clk = ~clk;

  cache_err_seq dut (
    .clk            (clk),
    .rst            (rst),
    .ic_err         (ic_err),
    .dc_err         (dc_err),
    .err_pc         (err_pc),
    .err_bd         (err_bd),
    .erl            (erl),
    .bev            (bev),
    .flush_ack      (flush_ack),
    .redirect_ack   (redirect_ack),
`ifdef CACHE_ERR_CNT_EN
    .cnt_clr        (cnt_clr),
    .err_cnt        (err_cnt),
`endif
    .flush_req      (flush_req),
    .cache_err      (cache_err),
    .pc_p           (pc_p),
    .bd_p           (bd_p),
    .erl_set        (erl_set),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err_src        (err_src),
    .flush_tmo      (flush_tmo),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete error sequence. ack_d = FLUSH cycle (1-based) on which flush_ack
  // is raised, 0 = never. rd_d = cycles redirect_ack is held low. Errors are
  // injected while busy to prove they are masked.
  task automatic run_seq(input logic ic, input logic dc, input logic [31:0] pc,
                         input logic bd, input logic b, input int ack_d,
                         input int rd_d, input logic clr);
    logic [31:0] vec;
    int          fl;
    int          exp_fl;
    logic        exp_tmo;
    exp_tmo = !(ack_d >= 1 && ack_d <= 16);
    exp_fl  = exp_tmo ? 16 : ack_d;
    vec     = b ? 32'hBFC00300 : 32'hA0000100;
    ic_err = ic; dc_err = dc; err_pc = pc; err_bd = bd; bev = ~b;
`ifdef CACHE_ERR_CNT_EN
    cnt_clr = clr;
    exp_cnt = clr ? 0 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
`endif
    last_pc = pc;
    last_bd = bd;
    @(negedge clk);
    ic_err = 1'b0; dc_err = 1'b0; err_pc = $urandom; err_bd = 1'($urandom);
`ifdef CACHE_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif
    fl = 0;
    for (int k = 0; k < 40 && flush_req === 1'b1; k++) begin
      fl++;
      flush_ack = (fl == ack_d);
      if ($urandom_range(3) == 0) dc_err = 1'b1;
      err_pc = $urandom;
      @(negedge clk);
      flush_ack = 1'b0;
      dc_err    = 1'b0;
    end
    chk("flush_len", fl, exp_fl);
    chk("commit_cache_err", cache_err, 1);
    chk("commit_erl_set", erl_set, 1);
    chk("commit_flush_req", flush_req, 0);
    chk("commit_pc_p", pc_p, last_pc);
    chk("commit_bd_p", bd_p, last_bd);
    chk("commit_err_src", err_src, {dc, ic});
    chk("commit_flush_tmo", flush_tmo, exp_tmo);
    bev = b;
    @(negedge clk);
    bev = ~b;
    chk("redir_valid", redirect_valid, 1);
    chk("redir_pc", redirect_pc, vec);
    chk("redir_cache_err", cache_err, 0);
    chk("redir_erl_set", erl_set, 0);
    for (int k = 0; k < rd_d; k++) begin
      dc_err = 1'b1; ic_err = 1'($urandom); err_pc = $urandom;
      @(negedge clk);
      dc_err = 1'b0; ic_err = 1'b0;
      chk("hold_valid", redirect_valid, 1);
      chk("hold_pc", redirect_pc, vec);
      chk("hold_pc_p", pc_p, last_pc);
      chk("hold_cache_err", cache_err, 0);
    end
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    chk("done_valid", redirect_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_pc_p", pc_p, last_pc);
`ifdef CACHE_ERR_CNT_EN
    chk("err_cnt", err_cnt, exp_cnt);
`endif
    $display("seq %0d: src=%b pc=%h bd=%b bev=%b ack_d=%0d flush=%0d tmo=%b rd_d=%0d",
             seq_id, {dc, ic}, pc, bd, b, ack_d, fl, exp_tmo, rd_d);
    seq_id++;
  endtask

  initial begin
    logic [1:0] s;
    logic       seen;
    rst = 1'b0; ic_err = 0; dc_err = 0; err_pc = '0; err_bd = 0;
    erl = 0; bev = 0; flush_ack = 0; redirect_ack = 0;
`ifdef CACHE_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif
    last_pc = '0; last_bd = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_flush_req", flush_req, 0);
    chk("rst_pc_p", pc_p, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_err_src", err_src, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic, simultaneous + BEV0, timeout, ack on timeout cycle, back-pressure.
    run_seq(1'b0, 1'b1, 32'h80001000, 1'b0, 1'b1, 2, 1, 1'b0);
    run_seq(1'b1, 1'b1, 32'h80002004, 1'b1, 1'b0, 1, 0, 1'b0);
    run_seq(1'b1, 1'b0, 32'h80003000, 1'b0, 1'b1, 0, 0, 1'b0);
    run_seq(1'b0, 1'b1, 32'h80004000, 1'b1, 1'b1, 16, 0, 1'b0);
    run_seq(1'b1, 1'b0, 32'h80005000, 1'b0, 1'b0, 3, 10, 1'b0);

    // Nested error with ERL already set is dropped.
    erl = 1'b1; ic_err = 1'b1; err_pc = 32'hDEADBEEF;
    @(negedge clk);
    ic_err = 1'b0;
    chk("nested_busy", busy, 0);
    chk("nested_flush_req", flush_req, 0);
    chk("nested_pc_p", pc_p, last_pc);
    @(negedge clk);
    chk("nested_busy2", busy, 0);
    erl = 1'b0;

    for (int i = 0; i < 40; i++) begin
      s = 2'($urandom_range(1, 3));
      run_seq(s[0], s[1], $urandom, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
              1'($urandom_range(7) == 0));
    end

    // Reset dropped mid-FLUSH clears everything without a clock edge.
    dc_err = 1'b1; err_pc = 32'h80009000;
    @(negedge clk);
    dc_err = 1'b0;
    chk("rstmid_flush_req", flush_req, 1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_flush_req0", flush_req, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cache_err", cache_err, 0);
    chk("rstmid_pc_p", pc_p, 0);
    chk("rstmid_err_src", err_src, 0);
    chk("rstmid_redirect_pc", redirect_pc, 0);
    last_pc = '0; last_bd = 1'b0; exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (cache_err !== 1'b0 || erl_set !== 1'b0) seen = 1'b1;
    end
    chk("rstmid_no_commit", seen, 0);
    chk("rstmid_idle", busy, 0);
`ifdef CACHE_ERR_CNT_EN
    chk("rstmid_cnt", err_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      run_seq(1'b0, 1'b1, $urandom, 1'b0, 1'b1, 1, 0, 1'b0);
    end
    chk("cnt_saturated", err_cnt, 8'hFF);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cnt = 0;
    chk("cnt_cleared", err_cnt, 0);
    run_seq(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 2, 0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
